// File: rtl/wdb_agent.sv
// wdb_agent: write-data-buffer entry allocator, upstream write sink and dataram drain pipeline
module wdb_agent #(
  parameter int ENTRY_NUM   = 8,
  parameter int ENTRY_IDX_W = 3,
  parameter int ROB_IDX_W   = 5,
  parameter int TXNID_W     = 8,
  parameter int RD_DELAY    = 2,
  parameter int DONE_DELAY  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   alloc_vld,
  output logic [ENTRY_IDX_W-1:0] alloc_idx,
  input  logic                   alloc_rdy,
  input  logic                   us_wr_vld,
  input  logic [ENTRY_IDX_W-1:0] us_wr_idx,
  output logic                   us_wr_rdy,
  input  logic                   dw_req_vld,
  input  logic [ENTRY_IDX_W-1:0] dw_req_idx,
  input  logic [ROB_IDX_W-1:0]   dw_req_rob_id,
  input  logic [TXNID_W-1:0]     dw_req_txnid,
  output logic                   dw_req_rdy,
  output logic                   wdb_mem_en,
  output logic                   wdb_wr_en,
  output logic [ENTRY_IDX_W-1:0] wdb_addr,
  output logic                   dram_wr_vld,
  output logic [TXNID_W-1:0]     dram_wr_txnid,
  output logic                   wr_done,
  output logic [ROB_IDX_W-1:0]   wr_done_rob_id,
  output logic                   err
);
  typedef enum logic [1:0] {FREE, ALLOC, FULL, DRAIN} st_e;
  st_e                   st    [ENTRY_NUM];
  logic [DONE_DELAY-1:0] p_vld;
  logic [ROB_IDX_W-1:0]  p_rob [DONE_DELAY];
  logic [ENTRY_IDX_W-1:0] p_idx [DONE_DELAY];
  logic [TXNID_W-1:0]    p_txn [RD_DELAY];
  logic                  acc;
  always_comb begin
    alloc_vld = 1'b0;
    alloc_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--)
      if (st[i] == FREE) begin
        alloc_vld = 1'b1;
        alloc_idx = ENTRY_IDX_W'(i);
      end
  end
  // the single SRAM port favours upstream writes; a stalled request is held by the arbiter
  assign us_wr_rdy      = 1'b1;
  assign dw_req_rdy     = ~us_wr_vld;
  assign acc            = dw_req_vld & dw_req_rdy;
  assign wdb_mem_en     = us_wr_vld | acc;
  assign wdb_wr_en      = us_wr_vld;
  assign wdb_addr       = us_wr_vld ? us_wr_idx : acc ? dw_req_idx : '0;
  assign dram_wr_vld    = p_vld[RD_DELAY-1];
  assign dram_wr_txnid  = p_txn[RD_DELAY-1];
  assign wr_done        = p_vld[DONE_DELAY-1];
  assign wr_done_rob_id = p_rob[DONE_DELAY-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) st[i] <= FREE;
      for (int i = 0; i < DONE_DELAY; i++) begin
        p_rob[i] <= '0;
        p_idx[i] <= '0;
      end
      for (int i = 0; i < RD_DELAY; i++) p_txn[i] <= '0;
      p_vld <= '0;
      err   <= 1'b0;
    end else begin
      p_vld    <= {p_vld[DONE_DELAY-2:0], acc};
      p_rob[0] <= acc ? dw_req_rob_id : '0;
      p_idx[0] <= acc ? dw_req_idx : '0;
      p_txn[0] <= acc ? dw_req_txnid : '0;
      for (int i = 1; i < DONE_DELAY; i++) begin
        p_rob[i] <= p_rob[i-1];
        p_idx[i] <= p_idx[i-1];
      end
      for (int i = 1; i < RD_DELAY; i++) p_txn[i] <= p_txn[i-1];
      err <= err | (us_wr_vld && st[us_wr_idx] != ALLOC) | (acc && st[dw_req_idx] != FULL);
      // later assignments win: release overrides drain, drain overrides alloc
      if (alloc_vld && alloc_rdy) st[alloc_idx] <= ALLOC;
      if (us_wr_vld && st[us_wr_idx] == ALLOC) st[us_wr_idx] <= FULL;
      if (acc) st[dw_req_idx] <= DRAIN;
      if (wr_done) st[p_idx[DONE_DELAY-1]] <= FREE;
    end
  end
endmodule

// File: tb/tb_wdb_agent.sv
// tb_wdb_agent: directed and randomized checks of wdb_agent against a cycle-timestamped entry model
module tb_wdb_agent;
  localparam int N = 8, IW = 3, RW = 5, TW = 8, RD = 2, DD = 4;
  localparam int S_FREE = 0, S_ALLOC = 1, S_FULL = 2, S_DRAIN = 3;
  logic clk = 1'b0, rst = 1'b0;
  logic alloc_vld, alloc_rdy = 1'b0, us_wr_vld = 1'b0, us_wr_rdy, dw_req_vld = 1'b0, dw_req_rdy;
  logic [IW-1:0] alloc_idx, us_wr_idx = '0, dw_req_idx = '0, wdb_addr;
  logic [RW-1:0] dw_req_rob_id = '0, wr_done_rob_id;
  logic [TW-1:0] dw_req_txnid = '0, dram_wr_txnid;
  logic wdb_mem_en, wdb_wr_en, dram_wr_vld, wr_done, err;
  always #5 clk = ~clk;
  wdb_agent dut (
    .clk(clk), .rst(rst), .alloc_vld(alloc_vld), .alloc_idx(alloc_idx), .alloc_rdy(alloc_rdy),
    .us_wr_vld(us_wr_vld), .us_wr_idx(us_wr_idx), .us_wr_rdy(us_wr_rdy),
    .dw_req_vld(dw_req_vld), .dw_req_idx(dw_req_idx), .dw_req_rob_id(dw_req_rob_id),
    .dw_req_txnid(dw_req_txnid), .dw_req_rdy(dw_req_rdy), .wdb_mem_en(wdb_mem_en),
    .wdb_wr_en(wdb_wr_en), .wdb_addr(wdb_addr), .dram_wr_vld(dram_wr_vld),
    .dram_wr_txnid(dram_wr_txnid), .wr_done(wr_done), .wr_done_rob_id(wr_done_rob_id), .err(err)
  );
  typedef struct {int t; logic [RW-1:0] rob; logic [TW-1:0] txn; int idx;} req_t;
  req_t pend[$];
  int   mst[N];
  bit   merr;
  int   cyc = 0, errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input int s);
    int q[$];
    foreach (mst[i]) if (mst[i] == s) q.push_back(i);
    return q.size() > 0 ? q[$urandom_range(0, q.size() - 1)] : -1;
  endfunction
  task automatic model_reset();
    foreach (mst[i]) mst[i] = S_FREE;
    merr = 1'b0;
    pend.delete();
  endtask
  task automatic idle_inputs();
    alloc_rdy = 1'b0; us_wr_vld = 1'b0; dw_req_vld = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    model_reset();
    chk("rst_alloc_vld", alloc_vld, 1);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_us_wr_rdy", us_wr_rdy, 1);
    chk("rst_dw_req_rdy", dw_req_rdy, 1);
    chk("rst_mem_en", wdb_mem_en, 0);
    chk("rst_dram_wr_vld", dram_wr_vld, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc += 2;
  endtask
  // one clock: inputs were driven at posedge+1; check mid-cycle, then advance the model
  task automatic cycle();
    bit av = 1'b0, dv = 1'b0, wd = 1'b0;
    int ai = 0, di = 0;
    int pre[N];
    logic [TW-1:0] dt = '0;
    logic [RW-1:0] dr = '0;
    #3;
    for (int i = N - 1; i >= 0; i--) if (mst[i] == S_FREE) begin av = 1'b1; ai = i; end
    foreach (pend[k]) begin
      if (pend[k].t == cyc - RD) begin dv = 1'b1; dt = pend[k].txn; end
      if (pend[k].t == cyc - DD) begin wd = 1'b1; dr = pend[k].rob; di = pend[k].idx; end
    end
    chk("alloc_vld", alloc_vld, av);
    chk("alloc_idx", alloc_idx, ai);
    chk("us_wr_rdy", us_wr_rdy, 1);
    chk("dw_req_rdy", dw_req_rdy, !us_wr_vld);
    chk("mem_en", wdb_mem_en, us_wr_vld | dw_req_vld);
    chk("wr_en", wdb_wr_en, us_wr_vld);
    chk("addr", wdb_addr, us_wr_vld ? us_wr_idx : dw_req_vld ? dw_req_idx : 0);
    chk("dram_wr_vld", dram_wr_vld, dv);
    if (dv) chk("dram_wr_txnid", dram_wr_txnid, dt);
    chk("wr_done", wr_done, wd);
    if (wd) chk("wr_done_rob_id", wr_done_rob_id, dr);
    chk("err", err, merr);
    @(posedge clk); #1;
    pre = mst;
    if (av && alloc_rdy) mst[ai] = S_ALLOC;
    if (us_wr_vld) begin
      if (pre[us_wr_idx] == S_ALLOC) mst[us_wr_idx] = S_FULL;
      else merr = 1'b1;
    end
    if (dw_req_vld && !us_wr_vld) begin
      if (pre[dw_req_idx] != S_FULL) merr = 1'b1;
      mst[dw_req_idx] = S_DRAIN;
      pend.push_back('{cyc, dw_req_rob_id, dw_req_txnid, int'(dw_req_idx)});
    end
    if (wd) mst[di] = S_FREE;
    while (pend.size() > 0 && pend[0].t <= cyc - DD) void'(pend.pop_front());
    cyc++;
  endtask
  task automatic idle(input int n);
    idle_inputs();
    repeat (n) cycle();
  endtask
  initial begin
    bit stalled;
    int a, f;
    model_reset();
    do_reset();
    // single entry round trip
    alloc_rdy = 1'b1; cycle(); idle_inputs();
    us_wr_vld = 1'b1; us_wr_idx = 0; cycle(); idle_inputs();
    dw_req_vld = 1'b1; dw_req_idx = 0; dw_req_rob_id = 5; dw_req_txnid = 8'h3C;
    #1;
    chk("t2_req_mem_en", wdb_mem_en, 1);
    chk("t2_req_wr_en", wdb_wr_en, 0);
    chk("t2_req_addr", wdb_addr, 0);
    cycle();
    idle(1);
    chk("t2_dram_vld", dram_wr_vld, 1);
    chk("t2_dram_txn", dram_wr_txnid, 8'h3C);
    idle(2);
    chk("t2_done", wr_done, 1);
    chk("t2_done_rob", wr_done_rob_id, 5);
    chk("t2_busy_idx", alloc_idx, 1);
    idle(1);
    chk("t2_free_idx", alloc_idx, 0);
    // fill every entry, then drain entry 3
    alloc_rdy = 1'b1;
    repeat (8) cycle();
    idle_inputs();
    chk("t3_full_vld", alloc_vld, 0);
    chk("t3_full_idx", alloc_idx, 0);
    us_wr_vld = 1'b1; us_wr_idx = 3; cycle(); idle_inputs();
    dw_req_vld = 1'b1; dw_req_idx = 3; dw_req_rob_id = 7; dw_req_txnid = 8'h55; cycle();
    idle(3);
    chk("t3_done", wr_done, 1);
    chk("t3_still_full", alloc_vld, 0);
    idle(1);
    chk("t3_freed_vld", alloc_vld, 1);
    chk("t3_freed_idx", alloc_idx, 3);
    // write beats a simultaneous request, which is accepted next cycle
    us_wr_vld = 1'b1; us_wr_idx = 1; cycle();
    us_wr_idx = 0; dw_req_vld = 1'b1; dw_req_idx = 1; dw_req_rob_id = 9; dw_req_txnid = 8'hA1;
    #1;
    chk("t4_stall_rdy", dw_req_rdy, 0);
    chk("t4_stall_wr_en", wdb_wr_en, 1);
    chk("t4_stall_addr", wdb_addr, 0);
    cycle();
    us_wr_vld = 1'b0;
    #1;
    chk("t4_accept_rdy", dw_req_rdy, 1);
    chk("t4_accept_wr_en", wdb_wr_en, 0);
    chk("t4_accept_addr", wdb_addr, 1);
    cycle();
    idle(6);
    // legal random traffic
    do_reset();
    stalled = 1'b0;
    repeat (400) begin
      alloc_rdy = 1'($urandom_range(0, 1));
      if (!stalled) begin
        f = pick(S_FULL);
        dw_req_vld = (f >= 0) && ($urandom_range(0, 2) != 0);
        if (dw_req_vld) begin
          dw_req_idx = IW'(f);
          dw_req_rob_id = RW'($urandom);
          dw_req_txnid = TW'($urandom);
        end
      end
      a = pick(S_ALLOC);
      us_wr_vld = (a >= 0) && ($urandom_range(0, 1) != 0);
      if (us_wr_vld) us_wr_idx = IW'(a);
      stalled = dw_req_vld && us_wr_vld;
      cycle();
      if (!stalled) dw_req_vld = 1'b0;
      us_wr_vld = 1'b0;
    end
    idle(6);
    chk("rand_err", err, 0);
    // protocol errors are sticky
    do_reset();
    alloc_rdy = 1'b1; cycle(); idle_inputs();
    dw_req_vld = 1'b1; dw_req_idx = 0; dw_req_rob_id = 3; dw_req_txnid = 8'h11; cycle(); idle_inputs();
    chk("t5_req_err", err, 1);
    us_wr_vld = 1'b1; us_wr_idx = 5; cycle(); idle_inputs();
    idle(6);
    chk("t5_sticky_err", err, 1);
    // reset while two entries drain
    do_reset();
    alloc_rdy = 1'b1; repeat (2) cycle(); idle_inputs();
    us_wr_vld = 1'b1; us_wr_idx = 0; cycle();
    us_wr_idx = 1; cycle(); idle_inputs();
    dw_req_vld = 1'b1; dw_req_idx = 0; dw_req_rob_id = 1; dw_req_txnid = 8'h21; cycle();
    dw_req_idx = 1; dw_req_rob_id = 2; dw_req_txnid = 8'h22; cycle();
    idle(1);
    do_reset();
    chk("t6_wr_done", wr_done, 0);
    chk("t6_alloc_idx", alloc_idx, 0);
    idle(6);
    chk("t6_all_free", alloc_vld, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
